// File: rtl/twiddle_gen_qw.sv
`default_nettype none
// ---------------------------------------------------------------------------
// twiddle_gen_qw : FFT twiddle generator from a quarter-wave sine table
// Revision 1.0
// ---------------------------------------------------------------------------
module twiddle_gen_qw #(
  parameter int LOG2N       = 7,
  parameter int DW          = 16,
  parameter     c_INIT_FILE = "NONE",
  parameter int CNT_W       = LOG2N + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic                    in_valid,
  input  logic [LOG2N-1:0]        in_k,
  input  logic                    sw_start,
  input  logic [LOG2N-1:0]        sw_base,
  input  logic [LOG2N-1:0]        sw_stride,
  input  logic [CNT_W-1:0]        sw_count,
  output logic                    busy,
  output logic                    sw_done,
  output logic                    drop,
  output logic                    out_valid,
  output logic [LOG2N-1:0]        out_k,
  output logic signed [DW-1:0]    tw_re,
  output logic signed [DW-1:0]    tw_im
);

  localparam int              c_AW       = LOG2N - 1;
  localparam int              c_Q        = 1 << (LOG2N - 2);
  localparam logic [c_AW-1:0] c_Q_ADDR   = c_AW'(c_Q);
  localparam bit              c_ZERO_TAB = (c_INIT_FILE == "NONE");

  // T[i] = round(sin(pi*i/(N/2)) * (2^(DW-1)-1)), evaluated in 60-bit fixed point
  // with a Taylor series; any c_INIT_FILE other than "NONE" selects this table.
  function automatic logic [DW-1:0] sine_entry(input int idx);
    logic [127:0] x, x2, term, acc, prod;
    x    = (128'h3243F6A8885A308D * 128'(idx)) / 128'(2 * c_Q);
    x2   = (x * x) >> 60;
    term = x;
    acc  = x;
    for (int n = 1; n <= 13; n++) begin
      term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
      if ((n % 2) == 1) acc = acc - term;
      else              acc = acc + term;
    end
    prod = (acc * ((128'd1 << (DW - 1)) - 128'd1) + (128'd1 << 59)) >> 60;
    return DW'(prod);
  endfunction

  logic [DW-1:0] tab [c_Q+1];

  for (genvar gi = 0; gi <= c_Q; gi++) begin : g_tab
    if (c_ZERO_TAB) begin : g_zero
      assign tab[gi] = '0;
    end else begin : g_sine
      localparam logic [DW-1:0] c_VAL = sine_entry(gi);
      assign tab[gi] = c_VAL;
    end
  end

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [LOG2N-1:0]  idx_q, idx_d, stride_q, stride_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              drop_q, drop_d;

  logic              inj_valid, inj_last;
  logic [LOG2N-1:0]  inj_k;

  logic              s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic [LOG2N-1:0]  s1_k_q, s1_k_d;
  logic [1:0]        s1_quad_q, s1_quad_d;
  logic [c_AW-1:0]   s1_addr_a_q, s1_addr_a_d, s1_addr_b_q, s1_addr_b_d;

  logic              s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic [LOG2N-1:0]  s2_k_q, s2_k_d;
  logic [1:0]        s2_quad_q, s2_quad_d;
  logic [DW-1:0]     s2_ta_q, s2_ta_d, s2_tb_q, s2_tb_d;

  logic              out_valid_q, out_valid_d, sw_done_q, sw_done_d;
  logic [LOG2N-1:0]  out_k_q, out_k_d;
  logic [DW-1:0]     tw_re_q, tw_re_d, tw_im_q, tw_im_d;
  logic [DW-1:0]     neg_a, neg_b;

  always_comb begin : p_ctrl
    state_d   = state_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    stride_d  = stride_q;
    drop_d    = 1'b0;
    inj_valid = 1'b0;
    inj_last  = 1'b0;
    inj_k     = in_k;
    unique case (state_q)
      ST_IDLE: begin
        if (sw_start) begin
          drop_d = in_valid;
          if (sw_count != '0) begin
            state_d  = ST_RUN;
            idx_d    = sw_base;
            rem_d    = sw_count;
            stride_d = sw_stride;
          end
        end else if (in_valid) begin
          inj_valid = 1'b1;
          inj_k     = in_k;
        end
      end
      ST_RUN: begin
        drop_d    = sw_start | in_valid;
        inj_valid = 1'b1;
        inj_k     = idx_q;
        idx_d     = idx_q + stride_q;
        rem_d     = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          inj_last = 1'b1;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drop_d = sw_start | in_valid;
        // Leave as the tagged last index enters the output register.
        if (s2_valid_q && s2_last_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : p_pipe
    s1_valid_d  = inj_valid;
    s1_last_d   = inj_last;
    s1_k_d      = inj_k;
    s1_quad_d   = inj_k[LOG2N-1 -: 2];
    s1_addr_a_d = {1'b0, inj_k[LOG2N-3:0]};
    s1_addr_b_d = c_Q_ADDR - {1'b0, inj_k[LOG2N-3:0]};

    s2_valid_d  = s1_valid_q;
    s2_last_d   = s1_last_q;
    s2_k_d      = s1_k_q;
    s2_quad_d   = s1_quad_q;
    s2_ta_d     = tab[s1_addr_a_q];
    s2_tb_d     = tab[s1_addr_b_q];

    neg_a       = '0 - s2_ta_q;
    neg_b       = '0 - s2_tb_q;
    out_valid_d = s2_valid_q;
    sw_done_d   = s2_valid_q & s2_last_q;
    out_k_d     = out_k_q;
    tw_re_d     = tw_re_q;
    tw_im_d     = tw_im_q;
    if (s2_valid_q) begin
      out_k_d = s2_k_q;
      // ta = T[r], tb = T[Q-r]; tw_im carries -sin.
      unique case (s2_quad_q)
        2'd0:    begin tw_re_d = s2_tb_q; tw_im_d = neg_a;   end
        2'd1:    begin tw_re_d = neg_a;   tw_im_d = neg_b;   end
        2'd2:    begin tw_re_d = neg_b;   tw_im_d = s2_ta_q; end
        default: begin tw_re_d = s2_ta_q; tw_im_d = s2_tb_q; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      stride_q    <= '0;
      rem_q       <= '0;
      drop_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_k_q      <= '0;
      s1_quad_q   <= '0;
      s1_addr_a_q <= '0;
      s1_addr_b_q <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_k_q      <= '0;
      s2_quad_q   <= '0;
      s2_ta_q     <= '0;
      s2_tb_q     <= '0;
      out_valid_q <= 1'b0;
      sw_done_q   <= 1'b0;
      out_k_q     <= '0;
      tw_re_q     <= '0;
      tw_im_q     <= '0;
    end else if (clk_en) begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      stride_q    <= stride_d;
      rem_q       <= rem_d;
      drop_q      <= drop_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_k_q      <= s1_k_d;
      s1_quad_q   <= s1_quad_d;
      s1_addr_a_q <= s1_addr_a_d;
      s1_addr_b_q <= s1_addr_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      s2_k_q      <= s2_k_d;
      s2_quad_q   <= s2_quad_d;
      s2_ta_q     <= s2_ta_d;
      s2_tb_q     <= s2_tb_d;
      out_valid_q <= out_valid_d;
      sw_done_q   <= sw_done_d;
      out_k_q     <= out_k_d;
      tw_re_q     <= tw_re_d;
      tw_im_q     <= tw_im_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign sw_done   = sw_done_q;
  assign drop      = drop_q;
  assign out_valid = out_valid_q;
  assign out_k     = out_k_q;
  assign tw_re     = $signed(tw_re_q);
  assign tw_im     = $signed(tw_im_q);

endmodule
`default_nettype wire

// File: tb/tb_twiddle_gen_qw.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_twiddle_gen_qw : randomized bench with a timestamp-based reference model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_twiddle_gen_qw;

  localparam int  LOG2N = 7;
  localparam int  DW    = 16;
  localparam int  CNT_W = LOG2N + 1;
  localparam int  N     = 1 << LOG2N;
  localparam real FS    = 32767.0;
  localparam real PI    = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 clk_en = 1'b1;
  logic                 in_valid = 1'b0;
  logic [LOG2N-1:0]     in_k = '0;
  logic                 sw_start = 1'b0;
  logic [LOG2N-1:0]     sw_base = '0;
  logic [LOG2N-1:0]     sw_stride = '0;
  logic [CNT_W-1:0]     sw_count = '0;
  logic                 busy, sw_done, drop, out_valid;
  logic [LOG2N-1:0]     out_k;
  logic signed [DW-1:0] tw_re, tw_im;

  twiddle_gen_qw #(
    .LOG2N(LOG2N), .DW(DW), .c_INIT_FILE("SINE"), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .in_valid(in_valid), .in_k(in_k),
    .sw_start(sw_start), .sw_base(sw_base), .sw_stride(sw_stride), .sw_count(sw_count),
    .busy(busy), .sw_done(sw_done), .drop(drop),
    .out_valid(out_valid), .out_k(out_k), .tw_re(tw_re), .tw_im(tw_im)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(0.5 - x);
  endfunction

  function automatic int exp_re(input int k);
    return rnd($cos(2.0 * PI * real'(k) / real'(N)) * FS);
  endfunction

  function automatic int exp_im(input int k);
    return rnd(-$sin(2.0 * PI * real'(k) / real'(N)) * FS);
  endfunction

  // Reference model: every accepted index is due at the output two enabled
  // edges after the edge that injects it; busy spans start edge .. last output.
  typedef struct { int due; int k; bit last; } pend_t;
  pend_t pend[$];
  int    sweep_q[$];
  int    en_cnt   = 0;
  int    busy_end = 0;
  bit    m_busy = 1'b0, m_valid = 1'b0, m_done = 1'b0, m_drop = 1'b0;
  int    m_k = 0;

  always @(posedge clk or negedge rst_n) begin : model
    pend_t p;
    int    kk;
    if (!rst_n) begin
      pend.delete();
      sweep_q.delete();
      en_cnt   = 0;
      busy_end = 0;
      m_busy   = 1'b0;
      m_valid  = 1'b0;
      m_done   = 1'b0;
      m_drop   = 1'b0;
    end else if (clk_en) begin
      en_cnt++;
      m_drop = 1'b0;
      if (!m_busy) begin
        if (sw_start) begin
          if (in_valid) m_drop = 1'b1;
          if (sw_count != 0) begin
            for (int j = 0; j < int'(sw_count); j++)
              sweep_q.push_back((int'(sw_base) + j * int'(sw_stride)) % N);
            busy_end = en_cnt + int'(sw_count) + 2;
          end
        end else if (in_valid) begin
          pend.push_back('{en_cnt + 2, int'(in_k), 1'b0});
        end
      end else begin
        if (sw_start || in_valid) m_drop = 1'b1;
        if (sweep_q.size() > 0) begin
          kk = sweep_q.pop_front();
          pend.push_back('{en_cnt + 2, kk, sweep_q.size() == 0});
        end
      end
      m_valid = 1'b0;
      m_done  = 1'b0;
      if (pend.size() > 0 && pend[0].due == en_cnt) begin
        p       = pend.pop_front();
        m_valid = 1'b1;
        m_k     = p.k;
        m_done  = p.last;
      end
      m_busy = (en_cnt < busy_end);
    end
  end

  int log_k[$];
  int done_cnt = 0;

  always @(negedge clk) begin : compare
    chk("busy", busy, m_busy);
    chk("out_valid", out_valid, m_valid);
    chk("sw_done", sw_done, m_done);
    chk("drop", drop, m_drop);
    if (m_valid) begin
      chk("out_k", out_k, m_k);
      chk("tw_re", tw_re, exp_re(m_k));
      chk("tw_im", tw_im, exp_im(m_k));
    end
    if (out_valid) begin
      log_k.push_back(int'(out_k));
      case (int'(out_k))
        0:   begin chk("lit_re_k0",   tw_re,  32767); chk("lit_im_k0",   tw_im,      0); end
        16:  begin chk("lit_re_k16",  tw_re,  23170); chk("lit_im_k16",  tw_im, -23170); end
        32:  begin chk("lit_re_k32",  tw_re,      0); chk("lit_im_k32",  tw_im, -32767); end
        64:  begin chk("lit_re_k64",  tw_re, -32767); chk("lit_im_k64",  tw_im,      0); end
        96:  begin chk("lit_re_k96",  tw_re,      0); chk("lit_im_k96",  tw_im,  32767); end
        112: begin chk("lit_re_k112", tw_re,  23170); chk("lit_im_k112", tw_im,  23170); end
        default: ;
      endcase
    end
    if (sw_done) done_cnt++;
  end

  task automatic drive(input bit iv, input int k, input bit ss, input int b,
                       input int s, input int c, input bit en);
    in_valid  = iv;
    in_k      = LOG2N'(k);
    sw_start  = ss;
    sw_base   = LOG2N'(b);
    sw_stride = LOG2N'(s);
    sw_count  = CNT_W'(c);
    clk_en    = en;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic check_log(input string name, input int exp_q[$]);
    chk({name, "_len"}, log_k.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_k.size(); i++)
      chk(name, log_k[i], exp_q[i]);
  endtask

  initial begin
    chk("model_re_k16", exp_re(16), 23170);
    chk("model_im_k112", exp_im(112), 23170);
    chk("model_im_k32", exp_im(32), -32767);

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Cardinal points, then the 45-degree points.
    drive(1, 0, 0, 0, 0, 0, 1);
    drive(1, 32, 0, 0, 0, 0, 1);
    drive(1, 64, 0, 0, 0, 0, 1);
    drive(1, 96, 0, 0, 0, 0, 1);
    idle(5);
    drive(1, 16, 0, 0, 0, 0, 1);
    idle(1);
    drive(1, 112, 0, 0, 0, 0, 1);
    idle(5);

    // Wrapping sweep.
    log_k.delete();
    done_cnt = 0;
    drive(0, 0, 1, 120, 4, 4, 1);
    idle(8);
    check_log("sweep_k", '{120, 124, 0, 4});
    chk("sweep_done_cnt", done_cnt, 1);

    // Collisions while running: every request dropped, sweep unchanged.
    log_k.delete();
    drive(0, 0, 1, 3, 5, 6, 1);
    for (int i = 0; i < 7; i++) drive(1, 9, 1, 50, 1, 3, 1);
    idle(6);
    check_log("collide_k", '{3, 8, 13, 18, 23, 28});

    // Zero-length sweep, then a sweep frozen by clk_en for 5 cycles.
    log_k.delete();
    drive(0, 0, 1, 7, 1, 0, 1);
    idle(4);
    chk("zero_sweep_outputs", log_k.size(), 0);
    drive(0, 0, 1, 10, 1, 5, 1);
    idle(2);
    for (int i = 0; i < 5; i++) drive(i % 2, 40, (i % 2) == 0, 1, 1, 2, 0);
    idle(10);
    check_log("freeze_k", '{10, 11, 12, 13, 14});

    // Asynchronous reset between clock edges mid-sweep.
    drive(0, 0, 1, 120, 4, 20, 1);
    idle(4);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_sw_done", sw_done, 0);
    chk("arst_drop", drop, 0);
    chk("arst_out_k", out_k, 0);
    chk("arst_tw_re", tw_re, 0);
    chk("arst_tw_im", tw_im, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    log_k.delete();
    done_cnt = 0;
    drive(0, 0, 1, 120, 4, 4, 1);
    idle(8);
    check_log("post_rst_k", '{120, 124, 0, 4});
    chk("post_rst_done_cnt", done_cnt, 1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 4) == 0, $urandom % N, ($urandom % 12) == 0,
            $urandom % N, $urandom % N, $urandom % 8, ($urandom % 8) != 0);
    end
    idle(30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/twiddle_gen_qw.md
Name: twiddle_gen_qw

Overview:
- Parametrised twiddle-factor generator for the FFT datapath. Successor to the fixed 128-entry sine ROM.
- Produces W_N^k = cos(2πk/N) − j·sin(2πk/N) for any power-of-two N.
- Stores only a quarter-wave sine table (N/4+1 entries) and reconstructs the full circle by quadrant symmetry.
- Two index sources: external single-index requests, or an internal sweep engine (base, stride, count) that feeds butterfly stages directly.

Parameters:
- LOG2N, 7, log2 of FFT length N; legal range 3..12.
- DW, 16, signed output width; table magnitude full scale is 2^(DW-1)−1.
- c_INIT_FILE, "NONE", hex file of N/4+1 unsigned DW-bit entries T[i] = round(sin(π·i/(N/2))·(2^(DW-1)−1)). "NONE" loads all zeros.
- CNT_W, LOG2N+1, width of the sweep count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- clk_en  in  1  global pipeline enable; 0 freezes every register.
- in_valid  in  1  external index request.
- in_k  in  LOG2N  external index k.
- sw_start  in  1  sweep start pulse.
- sw_base  in  LOG2N  first sweep index.
- sw_stride  in  LOG2N  index increment, taken modulo N.
- sw_count  in  CNT_W  number of indices to emit; 0 means none.
- busy  out  1  sweep engine active.
- sw_done  out  1  one-cycle pulse with the last sweep output.
- drop  out  1  one-cycle pulse when a request is discarded.
- out_valid  out  1  twiddle output valid.
- out_k  out  LOG2N  index belonging to the output.
- tw_re  out  DW  cos term, signed.
- tw_im  out  DW  −sin term, signed.

Behaviour:
- Reset (rst_n=0, asynchronous): busy, sw_done, drop and out_valid = 0; out_k, tw_re, tw_im = 0; FSM to IDLE; all pipeline valids cleared. Reset mid-sweep abandons the sweep with no sw_done.
- clk_en=0 holds all state and outputs. Inputs presented while clk_en=0 are ignored and not dropped-flagged.

Index decode:
- q = k[LOG2N-1:LOG2N-2]; r = k[LOG2N-3:0]; Q = N/4.
- q=0: cos=T[Q−r], sin=T[r].
- q=1: cos=−T[r], sin=T[Q−r].
- q=2: cos=−T[Q−r], sin=−T[r].
- q=3: cos=T[r], sin=−T[Q−r].
- tw_re = cos; tw_im = −sin.
- Negation is two's complement on DW bits. Table magnitude never exceeds 2^(DW-1)−1, so no overflow.

Pipeline (fixed latency 3 enabled cycles, one result per enabled cycle, no backpressure):
- S1 registers k, q and both table addresses.
- S2 performs the registered dual read of T.
- S3 applies sign and swap, and registers the outputs.
- out_valid is high for exactly one cycle per accepted index. out_k equals the accepted k.

Sweep FSM:
- IDLE: sw_start with sw_count>0 → RUN; load idx=sw_base and rem=sw_count; busy=1 from the next cycle. sw_start with sw_count=0 → stay IDLE, nothing emitted, no sw_done.
- RUN: each enabled cycle, inject idx into S1, then idx = (idx + sw_stride) mod N (natural LOG2N-bit wrap) and rem−−. When rem reaches 1 and is injected → DRAIN.
- DRAIN: wait until the last index exits S3. sw_done pulses coincident with that out_valid; busy drops the same cycle → IDLE.
- sw_start while busy: ignored, drop=1.

Source arbitration:
- External request accepted only when IDLE and no sw_start in the same cycle.
- in_valid with busy=1, or simultaneous with an accepted sw_start: request discarded, drop=1.
- A discarded in_valid and a discarded sw_start in the same cycle produce a single drop pulse.
- An accepted external request injects at S1 the same cycle it is accepted.
- The sweep's first index is injected the cycle after sw_start, so a preceding external request never collides with it.

Test Plan:
1. LOG2N=7, DW=16, table matching ROM_sin128 values; external k=0,32,64,96 on consecutive cycles → outputs 3 cycles later: (32767,0), (0,−32767), (−32767,0), (0,32767).
2. External k=16 (N=128) → tw_re=T[16]=23170, tw_im=−23170; k=112 → tw_re=23170, tw_im=+23170.
3. Sweep base=120, stride=4, count=4 → out_k sequence 120,124,0,4 with wrap. busy high from cycle after start until the last out_valid; sw_done on the 4th output only.
4. During RUN assert in_valid and sw_start → each cycle drop=1; no extra out_valid; sweep output unchanged.
5. sw_count=0 → no outputs, busy stays 0, no sw_done. Then clk_en low for 5 cycles mid-sweep → outputs and order preserved, latency stretched by exactly 5 cycles.
6. Deassert rst_n asynchronously mid-sweep (between clock edges) → all outputs 0 immediately. After release, a new sweep behaves per scenario 3.
